// File: rtl/gtech_mux_arb.sv
// gtech_mux_arb
//
// Registered N:1 multiplexer with valid/ready flow control on every input
// channel and on the output. The channel is picked either by an explicit
// select (MODE=0) or by a round-robin arbiter (MODE=1). A single output
// register gives a timing break while still allowing one transfer per
// cycle when the consumer keeps ZR high.
//
// Ports:
//   CLK   - clock, all state changes on the rising edge
//   RST   - synchronous active-high reset
//   LOCK  - (only with GTECH_MUX_ARB_LOCK_EN) keep granting the channel in ZCH
//   D     - packed channel data, channel i at D[i*W +: W]
//   DV    - per-channel valid
//   DR    - per-channel ready (one-hot or zero), combinational
//   MODE  - 0 = select-driven, 1 = round-robin
//   S     - channel select used in MODE=0
//   Z     - registered output data
//   ZCH   - index of the channel held in Z
//   ZV    - output valid
//   ZR    - output ready from the consumer
//
// Optional feature macro: GTECH_MUX_ARB_LOCK_EN adds the LOCK input.

module gtech_mux_arb #(
   parameter int N  = 8,
   parameter int W  = 1,
   parameter int SW = $clog2(N)
) (
   input  logic           CLK,
   input  logic           RST,
`ifdef GTECH_MUX_ARB_LOCK_EN
   input  logic           LOCK,
`endif
   input  logic [N*W-1:0] D,
   input  logic [N-1:0]   DV,
   output logic [N-1:0]   DR,
   input  logic           MODE,
   input  logic [SW-1:0]  S,
   output logic [W-1:0]   Z,
   output logic [SW-1:0]  ZCH,
   output logic           ZV,
   input  logic           ZR
);

   localparam logic [SW:0]   N_EXT = (SW+1)'(N);
   localparam logic [SW-1:0] LAST  = SW'(N-1);

   logic          ld;
   logic [SW-1:0] ptr;
   logic [SW-1:0] rr_idx;
   logic          rr_found;
   logic [SW-1:0] gidx;
   logic          gvalid;
   logic          take;
   logic          locked;
   logic          lock_hold;
   logic          advance;
   logic [SW-1:0] ptr_next;

`ifdef GTECH_MUX_ARB_LOCK_EN
   logic          ptr_moved;
`endif

   // The output register can take a new word when it is empty or when the
   // consumer is draining it this same cycle, which avoids a bubble.
   assign ld = !ZV || ZR;

   // Round-robin scan: walk the channels starting at the pointer, wrapping
   // past N-1 back to 0, and remember the first one that has valid set.
   always_comb begin
      int pos;
      pos      = 0;
      rr_idx   = '0;
      rr_found = 1'b0;
      for (int i = 0; i < N; i++) begin
         pos = int'(ptr) + i;
         if (pos >= N) pos = pos - N;
         if (!rr_found && DV[pos]) begin
            rr_found = 1'b1;
            rr_idx   = SW'(pos);
         end
      end
   end

   // Lock qualification. Locking needs a meaningful channel in ZCH, which is
   // the case once something has been held or the pointer has moved.
   always_comb begin
`ifdef GTECH_MUX_ARB_LOCK_EN
      lock_hold = MODE && LOCK;
      locked    = lock_hold && (ZV || ptr_moved);
`else
      lock_hold = 1'b0;
      locked    = 1'b0;
`endif
   end

   // Channel choice and grant. A select beyond the last channel never grants.
   // Reset suppresses every grant so nothing is accepted on the reset edge.
   always_comb begin
      gidx   = '0;
      gvalid = 1'b0;
      if (!MODE) begin
         gidx = S;
         if ({1'b0, S} < N_EXT) gvalid = DV[S];
      end else if (locked) begin
         gidx   = ZCH;
         gvalid = DV[ZCH];
      end else begin
         gidx   = rr_idx;
         gvalid = rr_found;
      end
      take = gvalid && ld && !RST;
      DR   = '0;
      if (take) DR[gidx] = 1'b1;
   end

   // The pointer only moves on a round-robin grant, to the channel after the
   // granted one, and is frozen while a lock is requested.
   assign advance  = take && MODE && !lock_hold;
   assign ptr_next = (gidx == LAST) ? '0 : gidx + 1'b1;

   // Output register and arbiter pointer. With no grant the data and channel
   // index are left stale; only the valid flag drops once the word is taken.
   always_ff @(posedge CLK) begin
      if (RST) begin
         Z   <= '0;
         ZCH <= '0;
         ZV  <= 1'b0;
         ptr <= '0;
      end else begin
         if (take) begin
            Z   <= D[int'(gidx)*W +: W];
            ZCH <= gidx;
            ZV  <= 1'b1;
         end else if (ZR) begin
            ZV  <= 1'b0;
         end
         if (advance) ptr <= ptr_next;
      end
   end

`ifdef GTECH_MUX_ARB_LOCK_EN
   // Remembers that the pointer has advanced since reset, which makes ZCH a
   // valid lock target even after the output has drained.
   always_ff @(posedge CLK) begin
      if (RST) ptr_moved <= 1'b0;
      else if (advance) ptr_moved <= 1'b1;
   end
`endif

endmodule
